framebuffer_fill_engine: RTL
============================

// Module: framebuffer_fill_engine
// PURPOSE
//   Hardware rectangle-fill writer for the 1024x768 frame buffer's write (arb) port, clocked on the CPU clock.
//   The CPU issues one command (two corners plus a colour).
//   The engine writes every covered pixel, at most one per cycle, through the arbiter grant.
//   The DVI controller reads the same frame buffer from the other port.
// PARAMETERS
//   FB_WIDTH     1024  pixels per line; must be a power of two
//   FB_WIDTH_LOG2  10  log2(FB_WIDTH); row base = y << FB_WIDTH_LOG2
//   FB_HEIGHT     768  lines per frame
//   ADDR_WIDTH     20  frame-buffer word address width
//   PIXEL_WIDTH     1  bits per pixel
//   COORD_WIDTH    11  width of the x and y coordinate fields
// PORTS
//   clk        in   1            CPU clock; the only clock
//   rst        in   1            synchronous, active-high reset
//   cmd_valid  in   1            command offered
//   cmd_ready  out  1            engine can accept a command (state IDLE)
//   cmd_x0     in   COORD_WIDTH  corner A, x coordinate
//   cmd_y0     in   COORD_WIDTH  corner A, y coordinate
//   cmd_x1     in   COORD_WIDTH  corner B, x coordinate (inclusive)
//   cmd_y1     in   COORD_WIDTH  corner B, y coordinate (inclusive)
//   cmd_color  in   PIXEL_WIDTH  fill value
//   busy       out  1            high from accept until done
//   done       out  1            one-cycle pulse when the fill completes
//   fb_we      out  1            write request to the arbiter
//   fb_gnt     in   1            arbiter grant; a write happens when fb_we & fb_gnt
//   fb_addr    out  ADDR_WIDTH   write address = y*FB_WIDTH + x
//   fb_din     out  PIXEL_WIDTH  write data = latched cmd_color
// BEHAVIOUR
//   Reset: state IDLE; cmd_ready=1; busy=0; done=0; fb_we=0; fb_addr=0; fb_din=0.
//   Reset mid-fill abandons the fill immediately; no further writes are issued.
//   Handshake and states:
//     - Accept on cmd_valid & cmd_ready in IDLE; the fields are latched and the state moves to SETUP.
//     - SETUP (1 cycle): normalise the corners: xl=min(x0,x1), xr=max(x0,x1), yt=min(y0,y1), yb=max(y0,y1).
//       Then set x=xl, y=yt, row_base=yt<<FB_WIDTH_LOG2. Next state FILL.
//     - FILL: fb_we=1, fb_addr=row_base+x, fb_din=colour. Address, x and y are registered outputs, not combinational.
//     - Stall: when fb_gnt=0 every output holds. Advance only on fb_we & fb_gnt.
//     - Advance: if x<xr then x++. Else x=xl, y++, row_base+=FB_WIDTH.
//     - The grant on the pixel (xr,yb) ends FILL: state moves to DONE and fb_we drops the next cycle.
//     - DONE (1 cycle): done=1, busy still 1. Next state IDLE, where cmd_ready=1 and a new command can be accepted.
//   Latency: accept at cycle N puts the first fb_we at N+2.
//     With fb_gnt held high, done pulses at N+2+P, where P=(xr-xl+1)*(yr-yt+1) pixels.
//   Degenerate 1x1 rectangle: exactly one write, then done.
//   cmd_valid while busy: ignored; cmd_ready=0. The command must be held by the source.
//   Arithmetic: row_base and the address are ADDR_WIDTH bits and never exceed FB_WIDTH*FB_HEIGHT-1 in range.
// CONFIGURATION
//   FB_FILL_CLIP_EN defined:
//     - In SETUP, xr is clamped to FB_WIDTH-1 and yb to FB_HEIGHT-1.
//     - If xl>=FB_WIDTH or yt>=FB_HEIGHT, the engine skips FILL and goes SETUP->DONE with zero writes.
//   FB_FILL_CLIP_EN undefined:
//     - The iteration covers the full rectangle.
//     - fb_we is forced to 0 for pixels with x>=FB_WIDTH or y>=FB_HEIGHT; those pixels advance without waiting for fb_gnt.
//     - Cycles are still spent on those pixels; no out-of-range address is ever written.
// STRUCTURE
//   Shared package fb_pkg:
//     - FB_WIDTH, FB_WIDTH_LOG2, FB_HEIGHT, ADDR_WIDTH, COORD_WIDTH.
//     - Fill-state enum {IDLE, SETUP, FILL, DONE}.
//   One sub-module, fill_rect_normalize: combinational min/max plus the optional clamp, and an "empty" flag for clipping.
//   The FSM, x/y counters and the row_base accumulator live in this module; no multiplier is used.
// TESTING
//   1. (0,0)-(3,1), colour 1, grant always high -> addresses 0,1,2,3,1024,1025,1026,1027.
//      fb_we runs for 8 consecutive cycles; done pulses 10 cycles after accept.
//   2. Swapped corners (5,9)-(2,7) -> same address set as (2,7)-(5,9).
//      The first address is 7170 and the last is 9221; 12 writes total.
//   3. fb_gnt toggled 1,0,1,0 on a 4-pixel line -> each address is held through its stall cycle.
//      There are no duplicate or skipped writes; done comes after 8 FILL cycles.
//   4. cmd_valid asserted during a fill -> cmd_ready=0 and the second command is not taken.
//      It is accepted in the cycle after the done pulse.
//   5. rst asserted mid-fill (after 3 of 16 writes) -> the next cycle has fb_we=0, cmd_ready=1 and busy=0.
//      There are no further writes.
//   6. (1020,766)-(1030,770):
//      - FB_FILL_CLIP_EN defined -> 8 writes, last address 767*1024+1023.
//      - FB_FILL_CLIP_EN undefined -> 55 iteration cycles, 8 writes, same address set.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, coordinate and address types, and the fill
// engine state encoding for the rectangle-fill write path.
package fb_pkg;

  localparam int unsigned FB_WIDTH      = 1024;
  localparam int unsigned FB_WIDTH_LOG2 = 10;
  localparam int unsigned FB_HEIGHT     = 768;
  localparam int unsigned ADDR_WIDTH    = 20;
  localparam int unsigned PIXEL_WIDTH   = 1;
  localparam int unsigned COORD_WIDTH   = 11;

  typedef logic [COORD_WIDTH-1:0] coord_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } fill_state_e;

  // First coordinate past the visible area on each axis, and the last visible one.
  localparam coord_t X_LIMIT = coord_t'(FB_WIDTH);
  localparam coord_t Y_LIMIT = coord_t'(FB_HEIGHT);
  localparam coord_t X_LAST  = coord_t'(FB_WIDTH - 1);
  localparam coord_t Y_LAST  = coord_t'(FB_HEIGHT - 1);

  // Start address of line y; FB_WIDTH is a power of two so this is a shift.
  function automatic addr_t row_base_of(input coord_t y);
    return {y[ADDR_WIDTH-FB_WIDTH_LOG2-1:0], {FB_WIDTH_LOG2{1'b0}}};
  endfunction

endpackage

// File: rtl/framebuffer_fill_engine_if.sv
// Command and frame-buffer write-port signals of the rectangle-fill engine.
// slave: the fill engine; master: the CPU command source plus the arbiter.
interface framebuffer_fill_engine_if;
  import fb_pkg::*;

  logic   cmd_valid;
  logic   cmd_ready;
  coord_t cmd_x0;
  coord_t cmd_y0;
  coord_t cmd_x1;
  coord_t cmd_y1;
  pixel_t cmd_color;
  logic   busy;
  logic   done;
  logic   fb_we;
  logic   fb_gnt;
  addr_t  fb_addr;
  pixel_t fb_din;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, fb_gnt,
    input  cmd_ready, busy, done, fb_we, fb_addr, fb_din
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, fb_gnt,
    output cmd_ready, busy, done, fb_we, fb_addr, fb_din
  );

endinterface

// File: rtl/fill_rect_normalize.sv
// Orders the two rectangle corners into left/right/top/bottom.
// With FB_FILL_CLIP_EN defined the far edges are clamped to the visible area
// and empty flags a rectangle lying wholly off-screen; otherwise empty is 0.
module fill_rect_normalize
  import fb_pkg::*;
(
  input  coord_t x0,
  input  coord_t y0,
  input  coord_t x1,
  input  coord_t y1,
  output coord_t xl,
  output coord_t xr,
  output coord_t yt,
  output coord_t yb,
  output logic   empty
);

  coord_t x_max;
  coord_t y_max;

  // Min/max of each axis, then the optional clamp against the screen edge.
  always_comb begin
    xl    = (x0 < x1) ? x0 : x1;
    x_max = (x0 < x1) ? x1 : x0;
    yt    = (y0 < y1) ? y0 : y1;
    y_max = (y0 < y1) ? y1 : y0;
`ifdef FB_FILL_CLIP_EN
    xr    = (x_max > X_LAST) ? X_LAST : x_max;
    yb    = (y_max > Y_LAST) ? Y_LAST : y_max;
    empty = (xl >= X_LIMIT) || (yt >= Y_LIMIT);
`else
    xr    = x_max;
    yb    = y_max;
    empty = 1'b0;
`endif
  end

endmodule

// File: rtl/framebuffer_fill_engine.sv
// Rectangle-fill writer for the frame buffer's arbitrated write port.
// Accepts one command (two corners plus a colour), then writes every covered
// pixel at most once per cycle, advancing only when the arbiter grants.
// Build option FB_FILL_CLIP_EN: clip the rectangle to the screen in SETUP.
// Without it the whole rectangle is walked and off-screen pixels are skipped
// (no write request, no wait for grant).
module framebuffer_fill_engine
  import fb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  framebuffer_fill_engine_if.slave   bus
);

  fill_state_e state_q;
  fill_state_e state_d;

  // Latched command
  coord_t x0_q;
  coord_t y0_q;
  coord_t x1_q;
  coord_t y1_q;
  pixel_t color_q;

  // Normalised bounds captured in SETUP
  coord_t xl_q;
  coord_t xr_q;
  coord_t yb_q;

  // Walk position; addr_q always equals row_base_q + x_q
  coord_t x_q;
  coord_t y_q;
  addr_t  row_base_q;
  addr_t  addr_q;

  coord_t n_xl;
  coord_t n_xr;
  coord_t n_yt;
  coord_t n_yb;
  logic   n_empty;

  logic   pix_we;
  logic   advance;
  logic   last_pix;

  fill_rect_normalize u_normalize (
    .x0    (x0_q),
    .y0    (y0_q),
    .x1    (x1_q),
    .y1    (y1_q),
    .xl    (n_xl),
    .xr    (n_xr),
    .yt    (n_yt),
    .yb    (n_yb),
    .empty (n_empty)
  );

  // Write request and step condition for the current pixel.
  always_comb begin
`ifdef FB_FILL_CLIP_EN
    pix_we   = (state_q == FILL);
`else
    pix_we   = (state_q == FILL) && (x_q < X_LIMIT) && (y_q < Y_LIMIT);
`endif
    // Off-screen pixels (pix_we low while filling) step without a grant.
    advance  = (state_q == FILL) && (!pix_we || bus.fb_gnt);
    last_pix = (x_q == xr_q) && (y_q == yb_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = n_empty ? DONE : FILL;
      end
      FILL: begin
        if (advance && last_pix) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.fb_we   = pix_we;
  assign bus.fb_addr = addr_q;
  assign bus.fb_din  = color_q;

  // Command latch, bound capture and raster walk; row_base steps by FB_WIDTH
  // per line so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      xl_q       <= '0;
      xr_q       <= '0;
      yb_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            x0_q    <= bus.cmd_x0;
            y0_q    <= bus.cmd_y0;
            x1_q    <= bus.cmd_x1;
            y1_q    <= bus.cmd_y1;
            color_q <= bus.cmd_color;
          end
        end
        SETUP: begin
          xl_q       <= n_xl;
          xr_q       <= n_xr;
          yb_q       <= n_yb;
          x_q        <= n_xl;
          y_q        <= n_yt;
          row_base_q <= row_base_of(n_yt);
          addr_q     <= row_base_of(n_yt) + addr_t'(n_xl);
        end
        FILL: begin
          // The final pixel leaves the walk registers where they are.
          if (advance && !last_pix) begin
            if (x_q < xr_q) begin
              x_q    <= x_q + 1'b1;
              addr_q <= addr_q + 1'b1;
            end else begin
              x_q        <= xl_q;
              y_q        <= y_q + 1'b1;
              row_base_q <= row_base_q + addr_t'(FB_WIDTH);
              addr_q     <= row_base_q + addr_t'(FB_WIDTH) + addr_t'(xl_q);
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
